// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : DEPTH x WIDTH register file with a per-register pending
//             (scoreboard) bit and a registered count of pending registers.
//             Optional macro REGFILE_SB_BYPASS_EN forwards write-back data to
//             the read ports in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    R1_in,
    input  logic [AW-1:0]    R2_in,
    output logic [WIDTH-1:0] R1_out,
    output logic [WIDTH-1:0] R2_out,
    output logic             R1_busy,
    output logic             R2_busy,
    input  logic             WE,
    input  logic [AW-1:0]    W_in,
    input  logic [WIDTH-1:0] Din,
    input  logic             ISS,
    input  logic [AW-1:0]    Iss_in,
    output logic [AW:0]      Pend_cnt
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic             w_we_ok;
    logic             w_iss_ok;
    logic             w_set;
    logic             w_clr;

    assign w_we_ok  = WE  && (W_in   != '0);
    assign w_iss_ok = ISS && (Iss_in != '0);

    // A same-register write+issue keeps the bit set, so it never counts as a clear.
    assign w_set = w_iss_ok && !pend_q[Iss_in];
    assign w_clr = w_we_ok && pend_q[W_in] && !(w_iss_ok && (Iss_in == W_in));

    always_comb begin
        pend_d = pend_q;
        if (w_we_ok) begin
            pend_d[W_in] = 1'b0;
        end
        if (w_iss_ok) begin
            pend_d[Iss_in] = 1'b1;
        end
        pend_d[0] = 1'b0;
        cnt_d = cnt_q + {{AW{1'b0}}, w_set} - {{AW{1'b0}}, w_clr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_we_ok) begin
                regs_q[W_in] <= Din;
            end
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Pend_cnt = cnt_q;

    always_comb begin
        R1_out  = (R1_in == '0) ? '0 : regs_q[R1_in];
        R2_out  = (R2_in == '0) ? '0 : regs_q[R2_in];
        R1_busy = pend_q[R1_in];
        R2_busy = pend_q[R2_in];
`ifdef REGFILE_SB_BYPASS_EN
        // Forwarded write clears busy unless a same-register issue re-arms it.
        if (rst_n && w_we_ok && (W_in == R1_in)) begin
            R1_out = Din;
            if (!(w_iss_ok && (Iss_in == R1_in))) begin
                R1_busy = 1'b0;
            end
        end
        if (rst_n && w_we_ok && (W_in == R2_in)) begin
            R2_out = Din;
            if (!(w_iss_ok && (Iss_in == R2_in))) begin
                R2_busy = 1'b0;
            end
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb: directed scenarios with
//             literal expectations plus randomized traffic against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [AW-1:0]    R1_in, R2_in, W_in, Iss_in;
    logic [WIDTH-1:0] R1_out, R2_out, Din;
    logic             R1_busy, R2_busy, WE, ISS;
    logic [AW:0]      Pend_cnt;

    regfile_sb #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .R1_in(R1_in), .R2_in(R2_in),
        .R1_out(R1_out), .R2_out(R2_out),
        .R1_busy(R1_busy), .R2_busy(R2_busy),
        .WE(WE), .W_in(W_in), .Din(Din),
        .ISS(ISS), .Iss_in(Iss_in),
        .Pend_cnt(Pend_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model: architectural register contents and pending set.
    logic [WIDTH-1:0] mreg [DEPTH];
    logic [DEPTH-1:0] mpend;
    int               errors = 0;
    int               checks = 0;
    bit               started = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mreg[i] = '0;
        mpend = '0;
    endtask

    task automatic model_edge();
        if (WE && W_in != 0) begin
            mreg[W_in]  = Din;
            mpend[W_in] = 1'b0;
        end
        if (ISS && Iss_in != 0) mpend[Iss_in] = 1'b1;
    endtask

    function automatic logic [WIDTH-1:0] exp_out(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = (a == 0) ? '0 : mreg[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (rst_n && WE && W_in != 0 && W_in == a) v = Din;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        logic b;
        b = (a == 0) ? 1'b0 : mpend[a];
`ifdef REGFILE_SB_BYPASS_EN
        if (rst_n && WE && W_in != 0 && W_in == a && !(ISS && Iss_in == a)) b = 1'b0;
`endif
        return b;
    endfunction

    // Compare process: every falling edge, outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("R1_out",   R1_out,   exp_out(R1_in));
            chk("R2_out",   R2_out,   exp_out(R2_in));
            chk("R1_busy",  R1_busy,  exp_busy(R1_in));
            chk("R2_busy",  R2_busy,  exp_busy(R2_in));
            chk("Pend_cnt", Pend_cnt, $countones(mpend));
        end
    end

    // Advance one cycle; inputs are changed only 1 time unit after negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; ISS = 1'b0;
    endtask

    task automatic issue(input int r);
        ISS = 1'b1; Iss_in = AW'(r); tick(); idle();
    endtask

    task automatic wback(input int r, input logic [WIDTH-1:0] d);
        WE = 1'b1; W_in = AW'(r); Din = d; tick(); idle();
    endtask

    initial begin
        rst_n = 1'b0; WE = 1'b0; ISS = 1'b0;
        R1_in = '0; R2_in = '0; W_in = '0; Iss_in = '0; Din = '0;
        model_clear();
        started = 1'b1;
        tick(); tick();
        rst_n = 1'b1;

        // Reset state.
        R1_in = 7; R2_in = 0; #1;
        chk("rst_r1", R1_out, 0);
        chk("rst_r2", R2_out, 0);
        chk("rst_busy", {R1_busy, R2_busy}, 0);
        chk("rst_cnt", Pend_cnt, 0);

        // Issue then write-back of register 5.
        R1_in = 5;
        issue(5); #1;
        chk("iss5_busy", R1_busy, 1);
        chk("iss5_cnt", Pend_cnt, 1);
        wback(5, 32'hDEADBEEF); #1;
        chk("wb5_data", R1_out, 32'hDEADBEEF);
        chk("wb5_busy", R1_busy, 0);
        chk("wb5_cnt", Pend_cnt, 0);

        // Same-edge issue and write to 9: data written, still pending.
        WE = 1'b1; W_in = 9; Din = 32'h12; ISS = 1'b1; Iss_in = 9;
        tick(); idle(); R1_in = 9; #1;
        chk("r9_data", R1_out, 32'h12);
        chk("r9_busy", R1_busy, 1);
        chk("r9_cnt", Pend_cnt, 1);
        WE = 1'b1; W_in = 0; Din = 32'hFF; ISS = 1'b1; Iss_in = 0;
        tick(); idle(); R1_in = 0; R2_in = 0; #1;
        chk("r0_data", R1_out, 0);
        chk("r0_busy", R2_busy, 0);
        chk("r0_cnt", Pend_cnt, 1);

        // Fill the scoreboard, drain it, then re-issue an already pending reg.
        for (int r = 1; r < DEPTH; r++) issue(r);
        #1 chk("full_cnt", Pend_cnt, 31);
        for (int r = 1; r < DEPTH; r++) wback(r, WIDTH'(r * 32'h01010101));
        #1 chk("drain_cnt", Pend_cnt, 0);
        issue(3); issue(3); #1;
        chk("reiss_cnt", Pend_cnt, 1);

        // Asynchronous reset between edges.
        issue(2); issue(4);
        R1_in = 2; R2_in = 4; #1;
        chk("pre_rst_cnt", Pend_cnt, 3);
        rst_n = 1'b0; model_clear(); #1;
        chk("arst_busy", {R1_busy, R2_busy}, 0);
        chk("arst_r1", R1_out, 0);
        chk("arst_cnt", Pend_cnt, 0);
        tick(); rst_n = 1'b1;

        // Same-cycle read of a register being written.
        wback(6, 32'h33);
        R1_in = 6; WE = 1'b1; W_in = 6; Din = 32'hA5; #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("byp_r1", R1_out, 32'hA5);
`else
        chk("nobyp_r1", R1_out, 32'h33);
`endif
        tick(); idle(); #1;
        chk("post_wr_r1", R1_out, 32'hA5);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0; model_clear();
                tick();
                rst_n = 1'b1;
            end
            WE     = ($urandom_range(0, 2) != 0);
            ISS    = ($urandom_range(0, 1) != 0);
            W_in   = AW'($urandom_range(0, DEPTH - 1));
            Iss_in = ($urandom_range(0, 5) == 0) ? W_in : AW'($urandom_range(0, DEPTH - 1));
            Din    = $urandom;
            R1_in  = ($urandom_range(0, 3) == 0) ? W_in : AW'($urandom_range(0, DEPTH - 1));
            R2_in  = ($urandom_range(0, 3) == 0) ? Iss_in : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
